check_move: RTL and testbench
=============================

Name: check_move

Overview:
- Move-legality checker for the Connect-4 game controller.
- Given the player's selected column and the seven per-column fill counts, it decides whether a piece can be dropped there, and reports the landing row, per-column full flags and a board-full (draw) flag.
- Sits between the column-select logic and the game FSM. The FSM advances a turn only on a valid_move pulse.

Parameters:
- ROWS, 6, number of rows per column; a column is full when its count is >= ROWS.
- CAP_W, 3, width of each column fill count and of target_row.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- move_req  input  1  request strobe; the check is evaluated on the rising edge where it is high
- sel_col  input  3  selected column, 0..6 legal
- col0_cap  input  CAP_W  pieces currently in column 0
- col1_cap  input  CAP_W  pieces currently in column 1
- col2_cap  input  CAP_W  pieces currently in column 2
- col3_cap  input  CAP_W  pieces currently in column 3
- col4_cap  input  CAP_W  pieces currently in column 4
- col5_cap  input  CAP_W  pieces currently in column 5
- col6_cap  input  CAP_W  pieces currently in column 6
- valid_move  output  1  one-cycle pulse: the requested move is legal
- invalid_move  output  1  one-cycle pulse: the requested move is illegal
- target_row  output  CAP_W  row the piece lands in; held until the next accepted check
- bad_col  output  1  sticky-per-check: the last request used sel_col = 7
- col_full  output  7  bit i = 1 when coli_cap >= ROWS (registered)
- board_full  output  1  all seven col_full bits set (registered)

Behaviour:
- Reset (rst low, asynchronous): valid_move=0, invalid_move=0, target_row=0, bad_col=0, col_full=0, board_full=0. Reset may assert at any cycle; outputs clear immediately, and any in-flight check is discarded.
- Per-column status, updated every cycle:
  - col_full[i] <= (coli_cap >= ROWS).
  - board_full <= &(next col_full), i.e. computed from the same-cycle cap inputs, not the old register.
  - Cap values above ROWS (e.g. 7) count as full.
- Check, one-cycle latency, on a rising edge with move_req=1:
  - If sel_col == 7: invalid_move<=1, valid_move<=0, bad_col<=1, target_row unchanged.
  - Else if cap[sel_col] >= ROWS: invalid_move<=1, valid_move<=0, bad_col<=0, target_row unchanged.
  - Else: valid_move<=1, invalid_move<=0, bad_col<=0, target_row<=cap[sel_col].
- On a rising edge with move_req=0: valid_move<=0 and invalid_move<=0. bad_col and target_row hold.
- valid_move and invalid_move are never high together, and each is exactly one cycle per request edge.
- A move_req held high for N cycles produces N independent checks, one per edge, each using that edge's inputs. The block does not update caps itself, so the caller must increment the count before relying on a repeated check.
- Cap inputs are sampled on the same edge as move_req. A cap change coincident with move_req uses the new (current-edge) value.
- Purely single-clock, no combinational input-to-output paths. Uses a 7-way mux on sel_col and seven >= comparators.

Test Plan:
- Reset: assert rst=0 mid-operation with valid_move high -> all outputs 0 immediately, and they stay 0 while rst=0.
- Legal move: all caps 0, sel_col=3, move_req pulse -> next cycle valid_move=1, target_row=0, invalid_move=0; the following cycle valid_move=0.
- Partly filled column: col5_cap=5, sel_col=5, move_req -> valid_move=1, target_row=5. Then col5_cap=6, same request -> invalid_move=1, target_row still 5, col_full[5]=1.
- Out-of-range column: sel_col=7, move_req -> invalid_move=1, bad_col=1. Next request with sel_col=0 and cap 0 -> valid_move=1, bad_col=0.
- Board full: all caps 6 -> one cycle later col_full=7'h7F, board_full=1, and any request gives invalid_move. Dropping col2_cap to 5 -> board_full=0 next cycle, and a request with sel_col=2 gives valid_move=1, target_row=5.
- Back-to-back: move_req high 3 cycles with sel_col=1 and col1_cap incrementing 0,1,2 -> three consecutive valid_move pulses with target_row 0,1,2.

Source files
------------

// File: rtl/check_move.sv
// Connect-4 move-legality checker: validates a column drop request against
// the per-column fill counts and reports landing row, full flags and draw.
module check_move #(
    parameter int unsigned ROWS  = 6,
    parameter int unsigned CAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move_req,
    input  logic [2:0]       sel_col,
    input  logic [CAP_W-1:0] col0_cap,
    input  logic [CAP_W-1:0] col1_cap,
    input  logic [CAP_W-1:0] col2_cap,
    input  logic [CAP_W-1:0] col3_cap,
    input  logic [CAP_W-1:0] col4_cap,
    input  logic [CAP_W-1:0] col5_cap,
    input  logic [CAP_W-1:0] col6_cap,
    output logic             valid_move,
    output logic             invalid_move,
    output logic [CAP_W-1:0] target_row,
    output logic             bad_col,
    output logic [6:0]       col_full,
    output logic             board_full
);

    // One extra bit so ROWS == 2**CAP_W still compares correctly.
    localparam logic [CAP_W:0] ROWS_W = ROWS[CAP_W:0];

    logic [CAP_W-1:0] caps [7];
    logic [6:0]       full_next;
    logic [CAP_W-1:0] sel_cap;
    logic             sel_full;

    always_comb begin
        caps[0] = col0_cap;
        caps[1] = col1_cap;
        caps[2] = col2_cap;
        caps[3] = col3_cap;
        caps[4] = col4_cap;
        caps[5] = col5_cap;
        caps[6] = col6_cap;
        full_next = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            full_next[i] = ({1'b0, caps[i]} >= ROWS_W);
        end
    end

    always_comb begin
        sel_cap  = '0;
        sel_full = 1'b0;
        case (sel_col)
            3'd0: begin sel_cap = col0_cap; sel_full = full_next[0]; end
            3'd1: begin sel_cap = col1_cap; sel_full = full_next[1]; end
            3'd2: begin sel_cap = col2_cap; sel_full = full_next[2]; end
            3'd3: begin sel_cap = col3_cap; sel_full = full_next[3]; end
            3'd4: begin sel_cap = col4_cap; sel_full = full_next[4]; end
            3'd5: begin sel_cap = col5_cap; sel_full = full_next[5]; end
            3'd6: begin sel_cap = col6_cap; sel_full = full_next[6]; end
            default: begin sel_cap = '0; sel_full = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_move   <= 1'b0;
            invalid_move <= 1'b0;
            target_row   <= '0;
            bad_col      <= 1'b0;
            col_full     <= '0;
            board_full   <= 1'b0;
        end else begin
            col_full   <= full_next;
            board_full <= &full_next;
            if (move_req) begin
                if (sel_col == 3'd7) begin
                    valid_move   <= 1'b0;
                    invalid_move <= 1'b1;
                    bad_col      <= 1'b1;
                end else if (sel_full) begin
                    valid_move   <= 1'b0;
                    invalid_move <= 1'b1;
                    bad_col      <= 1'b0;
                end else begin
                    valid_move   <= 1'b1;
                    invalid_move <= 1'b0;
                    bad_col      <= 1'b0;
                    target_row   <= sel_cap;
                end
            end else begin
                valid_move   <= 1'b0;
                invalid_move <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_check_move.sv
// Directed testbench for check_move: reset, legal/illegal drops, bad column,
// board-full detection and back-to-back requests.
module tb_check_move;

    logic       clk;
    logic       rst;
    logic       move_req;
    logic [2:0] sel_col;
    logic [2:0] cap [7];
    logic       valid_move;
    logic       invalid_move;
    logic [2:0] target_row;
    logic       bad_col;
    logic [6:0] col_full;
    logic       board_full;

    int checks = 0;
    int passed = 0;

    check_move #(.ROWS(6), .CAP_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .move_req     (move_req),
        .sel_col      (sel_col),
        .col0_cap     (cap[0]),
        .col1_cap     (cap[1]),
        .col2_cap     (cap[2]),
        .col3_cap     (cap[3]),
        .col4_cap     (cap[4]),
        .col5_cap     (cap[5]),
        .col6_cap     (cap[6]),
        .valid_move   (valid_move),
        .invalid_move (invalid_move),
        .target_row   (target_row),
        .bad_col      (bad_col),
        .col_full     (col_full),
        .board_full   (board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_caps(input logic [2:0] v);
        for (int i = 0; i < 7; i++) cap[i] = v;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (valid_move !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_move); else passed++;
        checks++; if (invalid_move !== 1'b0) $display("FAIL reset_invalid got %b want 0", invalid_move); else passed++;
        checks++; if (target_row !== 3'd0) $display("FAIL reset_target got %0d want 0", target_row); else passed++;
        checks++; if (bad_col !== 1'b0) $display("FAIL reset_bad_col got %b want 0", bad_col); else passed++;
        checks++; if (col_full !== 7'h00) $display("FAIL reset_col_full got %h want 00", col_full); else passed++;
        checks++; if (board_full !== 1'b0) $display("FAIL reset_board_full got %b want 0", board_full); else passed++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_legal();
        set_all_caps(3'd0);
        sel_col = 3'd3; move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++; if (valid_move !== 1'b1) $display("FAIL legal_valid got %b want 1", valid_move); else passed++;
        checks++; if (invalid_move !== 1'b0) $display("FAIL legal_invalid got %b want 0", invalid_move); else passed++;
        checks++; if (target_row !== 3'd0) $display("FAIL legal_target got %0d want 0", target_row); else passed++;
        step();
        checks++; if (valid_move !== 1'b0) $display("FAIL legal_pulse_end got %b want 0", valid_move); else passed++;
    endtask

    task automatic test_partial();
        cap[5] = 3'd5; sel_col = 3'd5; move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++; if (valid_move !== 1'b1) $display("FAIL partial_valid got %b want 1", valid_move); else passed++;
        checks++; if (target_row !== 3'd5) $display("FAIL partial_target got %0d want 5", target_row); else passed++;
        checks++; if (col_full[5] !== 1'b0) $display("FAIL partial_notfull got %b want 0", col_full[5]); else passed++;
        cap[5] = 3'd6; move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++; if (invalid_move !== 1'b1) $display("FAIL full_col_invalid got %b want 1", invalid_move); else passed++;
        checks++; if (valid_move !== 1'b0) $display("FAIL full_col_valid got %b want 0", valid_move); else passed++;
        checks++; if (target_row !== 3'd5) $display("FAIL full_col_target_hold got %0d want 5", target_row); else passed++;
        checks++; if (col_full !== 7'h20) $display("FAIL full_col_flags got %h want 20", col_full); else passed++;
        checks++; if (bad_col !== 1'b0) $display("FAIL full_col_bad got %b want 0", bad_col); else passed++;
        // Cap above ROWS still counts as full.
        cap[5] = 3'd7; move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++; if (invalid_move !== 1'b1) $display("FAIL cap7_invalid got %b want 1", invalid_move); else passed++;
        checks++; if (col_full !== 7'h20) $display("FAIL cap7_flags got %h want 20", col_full); else passed++;
        step();
        checks++; if (invalid_move !== 1'b0) $display("FAIL invalid_pulse_end got %b want 0", invalid_move); else passed++;
    endtask

    task automatic test_bad_col();
        set_all_caps(3'd0);
        sel_col = 3'd7; move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++; if (invalid_move !== 1'b1) $display("FAIL badcol_invalid got %b want 1", invalid_move); else passed++;
        checks++; if (bad_col !== 1'b1) $display("FAIL badcol_flag got %b want 1", bad_col); else passed++;
        checks++; if (target_row !== 3'd5) $display("FAIL badcol_target_hold got %0d want 5", target_row); else passed++;
        step();
        checks++; if (bad_col !== 1'b1) $display("FAIL badcol_sticky got %b want 1", bad_col); else passed++;
        sel_col = 3'd0; move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++; if (valid_move !== 1'b1) $display("FAIL badcol_recover_valid got %b want 1", valid_move); else passed++;
        checks++; if (bad_col !== 1'b0) $display("FAIL badcol_clear got %b want 0", bad_col); else passed++;
        checks++; if (target_row !== 3'd0) $display("FAIL badcol_recover_target got %0d want 0", target_row); else passed++;
    endtask

    task automatic test_board_full();
        set_all_caps(3'd6);
        step();
        checks++; if (col_full !== 7'h7F) $display("FAIL board_col_full got %h want 7f", col_full); else passed++;
        checks++; if (board_full !== 1'b1) $display("FAIL board_full_set got %b want 1", board_full); else passed++;
        sel_col = 3'd4; move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++; if (invalid_move !== 1'b1) $display("FAIL board_req_invalid got %b want 1", invalid_move); else passed++;
        checks++; if (valid_move !== 1'b0) $display("FAIL board_req_valid got %b want 0", valid_move); else passed++;
        cap[2] = 3'd5;
        step();
        checks++; if (board_full !== 1'b0) $display("FAIL board_full_clear got %b want 0", board_full); else passed++;
        checks++; if (col_full !== 7'h7B) $display("FAIL board_col2_open got %h want 7b", col_full); else passed++;
        sel_col = 3'd2; move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++; if (valid_move !== 1'b1) $display("FAIL board_col2_valid got %b want 1", valid_move); else passed++;
        checks++; if (target_row !== 3'd5) $display("FAIL board_col2_target got %0d want 5", target_row); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        set_all_caps(3'd0);
        sel_col = 3'd1; move_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cap[1] = 3'(k);
            step();
            checks++;
            if (valid_move !== 1'b1 || invalid_move !== 1'b0 || target_row !== 3'(k))
                $display("FAIL b2b_%0d got valid=%b invalid=%b row=%0d want valid=1 invalid=0 row=%0d",
                         k, valid_move, invalid_move, target_row, k);
            else passed++;
        end
        move_req = 1'b0;
        step();
        checks++; if (valid_move !== 1'b0) $display("FAIL b2b_end_valid got %b want 0", valid_move); else passed++;
        checks++; if (target_row !== 3'd2) $display("FAIL b2b_end_target got %0d want 2", target_row); else passed++;
    endtask

    task automatic test_reset_midop();
        set_all_caps(3'd0);
        cap[6] = 3'd6;
        sel_col = 3'd7; move_req = 1'b1;
        step();
        sel_col = 3'd4; cap[4] = 3'd3;
        step();
        checks++; if (valid_move !== 1'b1 || bad_col !== 1'b0) $display("FAIL midop_pre valid=%b bad=%b want 1 0", valid_move, bad_col); else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if (valid_move !== 1'b0 || invalid_move !== 1'b0 || target_row !== 3'd0 ||
            bad_col !== 1'b0 || col_full !== 7'h00 || board_full !== 1'b0)
            $display("FAIL midop_reset_immediate got v=%b i=%b row=%0d bad=%b cf=%h bf=%b want all 0",
                     valid_move, invalid_move, target_row, bad_col, col_full, board_full);
        else passed++;
        step();
        step();
        checks++;
        if (valid_move !== 1'b0 || invalid_move !== 1'b0 || target_row !== 3'd0 ||
            col_full !== 7'h00 || board_full !== 1'b0)
            $display("FAIL midop_reset_held got v=%b i=%b row=%0d cf=%h bf=%b want all 0",
                     valid_move, invalid_move, target_row, col_full, board_full);
        else passed++;
        move_req = 1'b0;
        #2 rst = 1'b1;
        step();
        checks++; if (col_full !== 7'h40) $display("FAIL post_reset_flags got %h want 40", col_full); else passed++;
    endtask

    initial begin
        rst = 1'b0;
        move_req = 1'b0;
        sel_col = 3'd0;
        set_all_caps(3'd0);
        test_reset();
        test_legal();
        test_partial();
        test_bad_col();
        test_board_full();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
